registered_channel_mux_module: RTL and testbench

//  Parametrised N:1 channel multiplexer with a registered output and valid/ready handshake on every port.

---
 rtl/registered_channel_mux_module_pkg.sv | 12 +
 rtl/registered_channel_mux_module_arbiter.sv | 43 ++++
 rtl/registered_channel_mux_module.sv | 81 ++++++++
 tb/tb_registered_channel_mux_module.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/registered_channel_mux_module_pkg.sv
// Shared definitions for the registered channel multiplexer family:
// mode encodings and a modulo pointer helper.
package registered_channel_mux_module_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int wrap_next(input int idx, input int channels);
    return (idx == channels - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/registered_channel_mux_module_arbiter.sv
// Round-robin arbiter: grants the first requesting channel at or after rr_ptr,
// and moves the pointer past the winner when told a transfer happened.
module round_robin_arbiter_module
  import registered_channel_mux_module_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  logic [SEL_W-1:0] rr_ptr;

  // Rotating priority search; the first hit stops further updates.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_valid && req[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (advance && grant_valid) begin
      rr_ptr <= SEL_W'(wrap_next(int'(grant), CHANNELS));
    end
  end

endmodule

// File: rtl/registered_channel_mux_module.sv
// N:1 channel multiplexer with a registered output stage and valid/ready on
// every port; channel chosen by sel (fixed mode) or round-robin.
module registered_channel_mux_module
  import registered_channel_mux_module_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int PAD = 1 << SEL_W;

  if (SEL_W != $clog2(CHANNELS) || CHANNELS < 2 || CHANNELS > 16) begin : g_bad_params
    $error("registered_channel_mux_module: SEL_W must equal clog2(CHANNELS), CHANNELS in 2..16");
  end

  logic [PAD-1:0]   valid_pad;
  logic             fixed_valid;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load_en;
  logic             transfer;
  logic [WIDTH-1:0] grant_data;

  // Padding to a power of two makes an out-of-range sel read as "not valid".
  assign valid_pad   = PAD'(in_valid);
  assign fixed_valid = valid_pad[sel];

  round_robin_arbiter_module #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arbiter (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (in_valid),
    .advance     (transfer && (mode == MODE_RR)),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  assign grant       = (mode == MODE_RR) ? rr_grant : sel;
  assign grant_valid = (mode == MODE_RR) ? rr_valid : fixed_valid;
  assign load_en     = !out_valid || out_ready;
  assign transfer    = load_en && grant_valid;
  assign grant_data  = in_data[int'(grant)*WIDTH +: WIDTH];

  // Reset gates the accept so no producer sees a handshake while held in reset.
  always_comb begin
    in_ready = '0;
    if (reset_n && transfer) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load_en) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= grant_data;
        out_chan <= grant;
      end
    end
  end

endmodule

// File: tb/tb_registered_channel_mux_module.sv
// Directed-vector bench for registered_channel_mux_module (WIDTH=8, CHANNELS=4)
// with hand-computed expectations.
module tb_registered_channel_mux_module;

  logic        clk;
  logic        reset_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  int vector_count;
  int miscompare_count;

  registered_channel_mux_module #(
    .WIDTH    (8),
    .CHANNELS (4),
    .SEL_W    (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic [3:0] valid,
                               input logic [1:0] s, input logic m, input logic rdy);
    in_data   = data;
    in_valid  = valid;
    sel       = s;
    mode      = m;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, "_data"},  32'(out_data),  32'(d));
    checkOutput({tag, "_chan"},  32'(out_chan),  32'(c));
  endtask

  initial begin
    vector_count     = 0;
    miscompare_count = 0;

    // Reset held with every channel valid
    reset_n = 1'b0;
    applyStimulus(32'h4433_2211, 4'hF, 2'd0, 1'b0, 1'b1);
    tick();
    tick();
    checkOut("reset", 1'b0, 8'h00, 2'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
    reset_n = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'b0001);
    tick();
    checkOut("release", 1'b1, 8'h11, 2'd0);

    // Fixed mode, sel=2
    applyStimulus(32'h00A5_0000, 4'b0100, 2'd2, 1'b0, 1'b1);
    #1;
    checkOutput("fixed2_in_ready", 32'(in_ready), 32'b0100);
    tick();
    checkOut("fixed2", 1'b1, 8'hA5, 2'd2);

    // Round-robin, all valid: 0,1,2,3,0
    applyStimulus(32'h4433_2211, 4'hF, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("rr%0d_in_ready", k), 32'(in_ready), 32'(1 << (k % 4)));
      tick();
      checkOut($sformatf("rr%0d", k), 1'b1, 8'((k % 4 + 1) * 8'h11), 2'(k % 4));
    end

    // Stall with changing inputs: held word 0x11 from channel 0
    for (int k = 0; k < 5; k++) begin
      applyStimulus(32'hA0B0_C0D0 + 32'(k), 4'hF, 2'(k), 1'(k), 1'b0);
      #1;
      checkOutput($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'h0);
      tick();
      checkOut($sformatf("stall%0d", k), 1'b1, 8'h11, 2'd0);
    end
    applyStimulus(32'h4433_2211, 4'h0, 2'd0, 1'b1, 1'b1);
    #1;
    checkOutput("drain_in_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("drain_once_valid", 32'(out_valid), 32'h0);

    // rr_ptr is 1 here; ch2 transfer moves it to 3
    applyStimulus(32'h0077_5A00, 4'b0100, 2'd0, 1'b1, 1'b1);
    #1;
    checkOutput("ptr3_in_ready", 32'(in_ready), 32'b0100);
    tick();
    checkOut("ptr3", 1'b1, 8'h77, 2'd2);
    // Wrap: only ch1 valid from rr_ptr=3
    applyStimulus(32'h0077_5A00, 4'b0010, 2'd0, 1'b1, 1'b1);
    #1;
    checkOutput("wrap_in_ready", 32'(in_ready), 32'b0010);
    tick();
    checkOut("wrap", 1'b1, 8'h5A, 2'd1);
    // rr_ptr must now be 2: {1,3} picks 3, {0,2} picks 2
    in_valid = 4'b1010;
    #1;
    checkOutput("ptr2_a_in_ready", 32'(in_ready), 32'b1000);
    in_valid = 4'b0101;
    #1;
    checkOutput("ptr2_b_in_ready", 32'(in_ready), 32'b0100);
    tick();
    checkOut("ptr2", 1'b1, 8'h77, 2'd2);

    // Fixed sel=3 with ch3 invalid, ch0 valid: no grant, word drains
    applyStimulus(32'h0000_00EE, 4'b0001, 2'd3, 1'b0, 1'b1);
    #1;
    checkOutput("nogrant_in_ready", 32'(in_ready), 32'h0);
    tick();
    checkOut("nogrant", 1'b0, 8'h77, 2'd2);

    // Reset mid-transfer drops the held word without a clock edge
    applyStimulus(32'h0000_0099, 4'b0001, 2'd0, 1'b0, 1'b1);
    tick();
    checkOut("pre_reset", 1'b1, 8'h99, 2'd0);
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    checkOut("async_reset", 1'b0, 8'h00, 2'd0);
    checkOutput("async_reset_in_ready", 32'(in_ready), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
